// File: rtl/bp_pkg.sv
// bp_pkg: counter and history helpers shared by the gshare predictor.
package bp_pkg;
  localparam int CTR_MAX_W = 4;
  localparam int HIST_MAX_W = 32;
  typedef logic [CTR_MAX_W-1:0] ctr_t;
  typedef logic [HIST_MAX_W-1:0] hist_t;
  function automatic ctr_t ctr_max(input int w);
    return ctr_t'((1 << w) - 1);
  endfunction
  function automatic ctr_t sat_inc(input ctr_t v, input int w);
    return (v == ctr_max(w)) ? v : v + 1'b1;
  endfunction
  function automatic ctr_t sat_dec(input ctr_t v);
    return (v == '0) ? v : v - 1'b1;
  endfunction
  function automatic ctr_t wnt_init(input int w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction
  // Shift a new outcome into the LSB, keeping only the low w bits.
  function automatic hist_t ghr_shift(input hist_t g, input logic b, input int w);
    return ((g << 1) | hist_t'(b)) & hist_t'((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/sat_counter_array.sv
// sat_counter_array: PHT of saturating counters with one train port and one direction read port.
module sat_counter_array
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] raddr_i,
  output logic                  rtaken_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] waddr_i,
  input  logic                  wtaken_i
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [CTR_BITS-1:0] pht_q [ENTRIES];
  logic [CTR_BITS-1:0] wr_d;
  always_comb begin
    wr_d = wtaken_i ? CTR_BITS'(sat_inc(ctr_t'(pht_q[waddr_i]), CTR_BITS))
                    : CTR_BITS'(sat_dec(ctr_t'(pht_q[waddr_i])));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_BITS'(wnt_init(CTR_BITS));
    end else if (we_i) begin
      pht_q[waddr_i] <= wr_d;
    end
  end
  // Read returns the pre-write value: no bypass from the training port.
  assign rtaken_o = pht_q[raddr_i][CTR_BITS-1];
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare/bimodal direction predictor with speculative GHR, repair and perf counters.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter bit GSHARE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC_F,
  input  logic                  branch_F,
  output logic                  predict_taken_F,
  output logic [INDEX_BITS-1:0] pht_index_F,
  output logic [HIST_BITS-1:0]  ghr_F,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] pht_index_E,
  input  logic [HIST_BITS-1:0]  ghr_E,
  input  logic                  branch_taken_E,
  input  logic                  mispredict_E,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);
  if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
    $error("gshare_predictor: HIST_BITS must lie in 1..INDEX_BITS");
  end
  if (CTR_BITS < 1 || CTR_BITS > CTR_MAX_W) begin : g_bad_ctr
    $error("gshare_predictor: CTR_BITS must lie in 1..4");
  end
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;
  logic [INDEX_BITS-1:0] ghr_ext, index_F;
  logic                  unused_pc;
  assign unused_pc = ^{PC_F[31:INDEX_BITS+2], PC_F[1:0]};
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr_q;
    index_F = PC_F[INDEX_BITS+1:2] ^ (GSHARE ? ghr_ext : '0);
    // A repair flushes the younger fetch, so its speculative shift is dropped.
    ghr_d = (update_en && mispredict_E) ? HIST_BITS'(ghr_shift(hist_t'(ghr_E), branch_taken_E, HIST_BITS))
          : branch_F ? HIST_BITS'(ghr_shift(hist_t'(ghr_q), predict_taken_F, HIST_BITS))
          : ghr_q;
    branch_count_d = (update_en && ~&branch_count_q) ? branch_count_q + 32'd1 : branch_count_q;
    mispredict_count_d = (update_en && mispredict_E && ~&mispredict_count_q)
                       ? mispredict_count_q + 32'd1 : mispredict_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ghr_q              <= ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
  sat_counter_array #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS)) u_pht (
    .clk      (clk),
    .rst      (rst),
    .raddr_i  (index_F),
    .rtaken_o (predict_taken_F),
    .we_i     (update_en),
    .waddr_i  (pht_index_E),
    .wtaken_i (branch_taken_E)
  );
  assign pht_index_F      = index_F;
  assign ghr_F            = ghr_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: gshare (default) and bimodal 3-bit instances checked against an arithmetic model.
module tb_gshare_predictor;
  logic        clk = 1'b0;
  logic        rst, branch_F, update_en, branch_taken_E, mispredict_E;
  logic [31:0] PC_F;
  logic [5:0]  pht_index_E, ghr_E;
  logic        p0, p1;
  logic [5:0]  i0, i1, g0;
  logic [2:0]  g1;
  logic [31:0] bc0, mc0, bc1, mc1;
  int checks = 0, failures = 0;
  int pht [2][64];
  int ghr [2];
  longint bc [2], mc [2];

  always #5 clk = ~clk;

  gshare_predictor u0 (
    .clk(clk), .rst(rst), .PC_F(PC_F), .branch_F(branch_F),
    .predict_taken_F(p0), .pht_index_F(i0), .ghr_F(g0),
    .update_en(update_en), .pht_index_E(pht_index_E), .ghr_E(ghr_E),
    .branch_taken_E(branch_taken_E), .mispredict_E(mispredict_E),
    .branch_count(bc0), .mispredict_count(mc0)
  );
  gshare_predictor #(.INDEX_BITS(6), .HIST_BITS(3), .CTR_BITS(3), .GSHARE(0)) u1 (
    .clk(clk), .rst(rst), .PC_F(PC_F), .branch_F(branch_F),
    .predict_taken_F(p1), .pht_index_F(i1), .ghr_F(g1),
    .update_en(update_en), .pht_index_E(pht_index_E), .ghr_E(ghr_E[2:0]),
    .branch_taken_E(branch_taken_E), .mispredict_E(mispredict_E),
    .branch_count(bc1), .mispredict_count(mc1)
  );

  function automatic int hb(int u); return u ? 3 : 6; endfunction
  function automatic int cb(int u); return u ? 3 : 2; endfunction
  function automatic int midx(int u);
    return (int'(PC_F / 4) % 64) ^ ((u == 0) ? ghr[u] : 0);
  endfunction
  function automatic int mpred(int u);
    return (pht[u][midx(u)] >= (1 << (cb(u) - 1))) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u0_pred", longint'(p0), mpred(0));
    chk("u0_idx", longint'(i0), midx(0));
    chk("u0_ghr", longint'(g0), ghr[0]);
    chk("u0_bcnt", longint'(bc0), bc[0]);
    chk("u0_mcnt", longint'(mc0), mc[0]);
    chk("u1_pred", longint'(p1), mpred(1));
    chk("u1_idx", longint'(i1), midx(1));
    chk("u1_ghr", longint'(g1), ghr[1]);
    chk("u1_bcnt", longint'(bc1), bc[1]);
    chk("u1_mcnt", longint'(mc1), mc[1]);
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic br, input logic up,
                       input logic [5:0] ie, input logic [5:0] ge, input logic tk, input logic mis);
    @(negedge clk);
    rst = r; PC_F = pc; branch_F = br; update_en = up;
    pht_index_E = ie; ghr_E = ge; branch_taken_E = tk; mispredict_E = mis;
    #1 check_all();
  endtask

  task automatic tick();
    int pr [2];
    @(posedge clk);
    for (int u = 0; u < 2; u++) pr[u] = mpred(u);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        for (int k = 0; k < 64; k++) pht[u][k] = (1 << (cb(u) - 1)) - 1;
        ghr[u] = 0; bc[u] = 0; mc[u] = 0;
      end else begin
        if (update_en && mispredict_E)
          ghr[u] = ((int'(ghr_E) % (1 << hb(u))) * 2 + int'(branch_taken_E)) % (1 << hb(u));
        else if (branch_F)
          ghr[u] = (ghr[u] * 2 + pr[u]) % (1 << hb(u));
        if (update_en) begin
          if (branch_taken_E) begin
            if (pht[u][pht_index_E] < (1 << cb(u)) - 1) pht[u][pht_index_E]++;
          end else if (pht[u][pht_index_E] > 0) pht[u][pht_index_E]--;
          if (bc[u] < 64'hFFFF_FFFF) bc[u]++;
          if (mispredict_E && mc[u] < 64'hFFFF_FFFF) mc[u]++;
        end
      end
    end
  endtask

  initial begin
    drive(1, 32'h40, 1, 1, 6'h10, 0, 1, 1); tick();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("reset_pred", longint'(p0), 0); chk("reset_ghr", longint'(g0), 0);
    chk("reset_bcnt", longint'(bc0), 0); chk("reset_mcnt", longint'(mc0), 0);
    tick();
    repeat (2) begin drive(0, 32'h40, 0, 1, 6'h10, 0, 1, 0); tick(); end
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0); chk("bimodal_tt", longint'(p1), 1); tick();
    drive(0, 32'h40, 0, 1, 6'h10, 0, 0, 0); tick();
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0); chk("bimodal_ttn", longint'(p1), 1); tick();
    drive(0, 32'h40, 0, 1, 6'h10, 0, 0, 0); tick();
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0); chk("bimodal_ttnn", longint'(p1), 0); tick();
    repeat (3) begin drive(0, 32'h40, 1, 0, 0, 0, 0, 0); tick(); end
    drive(0, 32'h40, 0, 1, 6'h3F, 6'b000101, 1, 1); chk("spec_nt_ghr", longint'(g0), 0); tick();
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("repair_ghr", longint'(g0), 6'b001011); chk("repair_idx", longint'(i0), 6'h1B); tick();
    drive(0, 32'h40, 1, 1, 6'h3E, 6'b000001, 0, 1); tick();
    drive(0, 32'h40, 0, 0, 0, 0, 0, 0); chk("repair_wins", longint'(g0), 6'b000010); tick();
    drive(0, 32'h1C, 0, 1, 6'h05, 0, 1, 0); chk("collision_same", longint'(p0), 0); tick();
    drive(0, 32'h1C, 0, 0, 0, 0, 0, 0); chk("collision_next", longint'(p0), 1); tick();
    repeat (8) begin drive(0, 32'h80, 0, 1, 6'h20, 0, 1, 0); tick(); end
    repeat (3) begin drive(0, 32'h80, 0, 1, 6'h20, 0, 0, 0); tick(); end
    drive(0, 32'h80, 0, 0, 0, 0, 0, 0); chk("ctr3_sat_hi", longint'(p1), 1); tick();
    drive(0, 32'h80, 0, 1, 6'h20, 0, 0, 0); tick();
    drive(0, 32'h80, 0, 0, 0, 0, 0, 0); chk("ctr3_down", longint'(p1), 0); tick();
    #2 force u1.branch_count_q = 32'hFFFF_FFFF;
    #1 release u1.branch_count_q;
    bc[1] = 64'hFFFF_FFFF;
    drive(0, 32'h80, 0, 1, 6'h21, 0, 1, 1); tick();
    drive(0, 32'h80, 0, 0, 0, 0, 0, 0); chk("bcnt_hold", longint'(bc1), 32'hFFFF_FFFF); tick();
    repeat (1500) begin
      drive(logic'($urandom_range(0, 99) == 0), $urandom, logic'($urandom), logic'($urandom),
            6'($urandom), 6'($urandom), logic'($urandom), logic'($urandom));
      tick();
    end
    drive(1, $urandom, 1, 1, 6'($urandom), 6'($urandom), 1, 1); tick();
    repeat (8) begin
      drive(0, $urandom, 0, 0, 0, 0, 0, 0);
      chk("midrst_pred0", longint'(p0), 0); chk("midrst_pred1", longint'(p1), 0);
      chk("midrst_ghr", longint'(g0), 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the 4-bit-indexed 2-bit bimodal BHT.
- Pattern history table (PHT) of N-bit saturating counters, indexed by PC XOR a global history register (GHR), or by PC alone in bimodal mode.
- GHR is updated speculatively at fetch and repaired on mispredict.
- Sits beside the fetch PC mux; Fetch (F) reads predictions, Execute (E) trains the table and repairs history. Includes performance counters.

Parameters:
- INDEX_BITS, 6, PHT has 2**INDEX_BITS entries, indexed from PC[INDEX_BITS+1:2].
- HIST_BITS, 6, GHR width. Legal range 1..INDEX_BITS; elaboration error otherwise.
- CTR_BITS, 2, counter width. Legal range 1..4.
- GSHARE, 1, 1 = index is PC bits XOR GHR (GHR zero-extended on the MSB side). 0 = PC bits only; GHR is still maintained.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- PC_F, input, 32, fetch PC.
- branch_F, input, 1, predecode: fetched instruction is a conditional branch.
- predict_taken_F, output, 1, MSB of the PHT counter at index_F. Combinational.
- pht_index_F, output, INDEX_BITS, index used for this prediction. Pipelined to E by the core.
- ghr_F, output, HIST_BITS, GHR value before this fetch's speculative shift. Pipelined to E.
- update_en, input, 1, resolved conditional branch in E.
- pht_index_E, input, INDEX_BITS, index carried from F.
- ghr_E, input, HIST_BITS, GHR snapshot carried from F.
- branch_taken_E, input, 1, actual outcome.
- mispredict_E, input, 1, predicted direction differed from outcome. Only meaningful when update_en=1.
- branch_count, output, 32, resolved branches. Saturating.
- mispredict_count, output, 32, mispredicts. Saturating.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All PHT entries become weakly-not-taken, value 2**(CTR_BITS-1)-1. For CTR_BITS=1 this is 0.
  - GHR is cleared to 0; both counters are cleared to 0.
  - Outputs are combinational from state, so after reset predict_taken_F=0 and ghr_F=0.
  - rst overrides update_en, mispredict_E and branch_F in the same cycle.
  - Reset mid-operation discards all history and training; no pending state survives.
- Prediction, zero latency:
  - index_F = PC_F[INDEX_BITS+1:2] ^ (GSHARE ? GHR : 0).
  - predict_taken_F = PHT[index_F][CTR_BITS-1].
- Speculative history: at posedge with branch_F=1 and no repair, GHR <= {GHR[HIST_BITS-2:0], predict_taken_F}. With HIST_BITS=1, GHR <= predict_taken_F.
- Repair: at posedge with update_en=1 and mispredict_E=1, GHR <= {ghr_E[HIST_BITS-2:0], branch_taken_E}.
  - Repair takes priority over any simultaneous fetch shift; the fetch-side shift that cycle is dropped, since the core flushes it.
- Training: at posedge with update_en=1, PHT[pht_index_E] moves one step toward branch_taken_E.
  - Increment saturates at 2**CTR_BITS-1; decrement saturates at 0.
  - Training uses pht_index_E directly and never recomputes from PC.
- Read/write collision: if index_F == pht_index_E in the same cycle, the prediction uses the pre-update value. There is no bypass.
- Counters, on update_en:
  - branch_count increments.
  - mispredict_count increments when mispredict_E=1.
  - Both hold at 32'hFFFF_FFFF.
- update_en=0 means mispredict_E and branch_taken_E are ignored.
- PC_F[1:0] and PC upper bits beyond INDEX_BITS+1 are ignored.

Decomposition:
- Package bp_pkg holds:
  - counter helper functions sat_inc and sat_dec, parametrised by width via a localparam-sized argument;
  - a weak-not-taken init constant function;
  - the shared ghr shift function used by both the speculative and repair paths.
- One sub-module, sat_counter_array: PHT storage, synchronous reset init, single write port, one combinational read port, parametrised by INDEX_BITS and CTR_BITS.
- The top level holds GHR, index hashing and the performance counters.

Test Plan:
- Reset, then PC_F=0x40 with default params -> predict_taken_F=0, ghr_F=0, branch_count=0, mispredict_count=0.
- GSHARE=0: update PC index 0x10 taken twice -> prediction at PC 0x40 is 1. One not-taken update -> still 1 (counter 2). A second not-taken -> 0.
- GSHARE=1: branch_F=1 on 3 fetches at PC 0x40, all predicted not-taken -> GHR=0. Then mispredict repair with ghr_E=6'b000101, taken=1 -> GHR=6'b001011, and pht_index_F for PC 0x40 becomes 0x10^0x0B=0x1B.
- Simultaneous branch_F=1 and mispredict repair -> GHR equals the repair value only, not shifted again.
- Collision: same index read and trained taken from counter 1 in the same cycle -> predict_taken_F=0 that cycle, 1 the next cycle.
- CTR_BITS=3: reset value 3. Eight taken updates -> counter 7, holds at 7. Force branch_count to 32'hFFFF_FFFF and update -> holds. Assert rst mid-stream -> all predictions 0, GHR 0.
